// File: rtl/elevator_motion_ctrl.sv
// Elevator motion/door sequencer: floor-by-floor travel, door timer, clear strobes.
// Optional `ELEV_CLOSE_BUTTON_EN` lets close_button cut the door timer short.
module elevator_motion_ctrl #(
  parameter int N          = 6,
  parameter int TRAVEL_CYC = 8,
  parameter int DOOR_CYC   = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_up_in,
  input  logic         req_down_in,
  input  logic         req_up_out,
  input  logic         req_down_out,
  input  logic         req_up_cur,
  input  logic         req_down_cur,
  input  logic         req_current,
  input  logic         req_up_max,
  input  logic         req_down_min,
  input  logic         open_button,
  input  logic         close_button,
  output logic [N-1:0] cur_floor,
  output logic         moving_up,
  output logic         moving_down,
  output logic         door_open,
  output logic [N-1:0] clr_floor,
  output logic         clr_up,
  output logic         clr_down
);

  localparam int TW = $clog2(TRAVEL_CYC + 1);
  localparam int DW = $clog2(DOOR_CYC + 1);

  typedef enum logic [1:0] {IDLE, MOVE, ARRIVE, DOOR} state_t;

  state_t        state, state_d;
  logic          dir_up, dir_d;
  logic [TW-1:0] tcnt, tcnt_d;
  logic [DW-1:0] dcnt, dcnt_d;
  logic [N-1:0]  floor_d;
  logic          up_req, dn_req;
  logic          close_hit;
  logic          door_entry;

`ifdef ELEV_CLOSE_BUTTON_EN
  assign close_hit = close_button;
`else
  logic close_unused;
  assign close_unused = close_button;
  assign close_hit    = 1'b0;
`endif

  // Travel requests are masked at the shaft ends so cur_floor stays one-hot.
  assign up_req = (req_up_in | req_up_out) & ~cur_floor[N-1];
  assign dn_req = (req_down_in | req_down_out) & ~cur_floor[0];

  always_comb begin
    state_d = state;
    dir_d   = dir_up;
    tcnt_d  = tcnt;
    dcnt_d  = dcnt;
    floor_d = cur_floor;
    case (state)
      IDLE: begin
        if (req_current) begin
          state_d = DOOR;
        end else if (dir_up) begin
          if (up_req) begin
            state_d = MOVE;
          end else if (dn_req) begin
            state_d = MOVE;
            dir_d   = 1'b0;
          end
        end else begin
          if (dn_req) begin
            state_d = MOVE;
          end else if (up_req) begin
            state_d = MOVE;
            dir_d   = 1'b1;
          end
        end
      end
      MOVE: begin
        if (tcnt == '0) begin
          floor_d = dir_up ? (cur_floor << 1) : (cur_floor >> 1);
          state_d = ARRIVE;
        end else begin
          tcnt_d = tcnt - TW'(1);
        end
      end
      ARRIVE: begin
        if (dir_up) begin
          if (req_up_cur | req_up_max) begin
            state_d = DOOR;
          end else if (up_req) begin
            state_d = MOVE;
          end else if (req_current) begin
            state_d = DOOR;
          end else if (dn_req) begin
            state_d = MOVE;
            dir_d   = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (req_down_cur | req_down_min) begin
            state_d = DOOR;
          end else if (dn_req) begin
            state_d = MOVE;
          end else if (req_current) begin
            state_d = DOOR;
          end else if (up_req) begin
            state_d = MOVE;
            dir_d   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DOOR: begin
        if (open_button) begin
          dcnt_d = DW'(DOOR_CYC - 1);
        end else if (dcnt == '0) begin
          state_d = IDLE;
        end else if (close_hit) begin
          dcnt_d = '0;
        end else begin
          dcnt_d = dcnt - DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == MOVE && state != MOVE) tcnt_d = TW'(TRAVEL_CYC - 1);
    if (state_d == DOOR && state != DOOR) dcnt_d = DW'(DOOR_CYC - 1);
  end

  assign door_entry = (state_d == DOOR) && (state != DOOR);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cur_floor   <= N'(1);
      dir_up      <= 1'b1;
      tcnt        <= '0;
      dcnt        <= '0;
      moving_up   <= 1'b0;
      moving_down <= 1'b0;
      door_open   <= 1'b0;
      clr_floor   <= '0;
      clr_up      <= 1'b0;
      clr_down    <= 1'b0;
    end else begin
      state       <= state_d;
      cur_floor   <= floor_d;
      dir_up      <= dir_d;
      tcnt        <= tcnt_d;
      dcnt        <= dcnt_d;
      moving_up   <= (state_d == MOVE) && dir_d;
      moving_down <= (state_d == MOVE) && !dir_d;
      door_open   <= (state_d == DOOR);
      clr_floor   <= door_entry ? floor_d : '0;
      clr_up      <= door_entry && dir_d;
      clr_down    <= door_entry && !dir_d;
    end
  end

endmodule

// File: tb/tb_elevator_motion_ctrl.sv
// Scoreboard bench for elevator_motion_ctrl: expected output vectors queued
// per cycle by the stimulus, popped and compared by a monitor after each edge.
module tb_elevator_motion_ctrl;

  localparam int N = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_up_in = 0, req_down_in = 0, req_up_out = 0, req_down_out = 0;
  logic req_up_cur = 0, req_down_cur = 0, req_current = 0;
  logic req_up_max = 0, req_down_min = 0;
  logic open_button = 0, close_button = 0;
  logic [N-1:0] cur_floor, clr_floor;
  logic moving_up, moving_down, door_open, clr_up, clr_down;

  elevator_motion_ctrl #(.N(N), .TRAVEL_CYC(8), .DOOR_CYC(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_up_in(req_up_in), .req_down_in(req_down_in),
    .req_up_out(req_up_out), .req_down_out(req_down_out),
    .req_up_cur(req_up_cur), .req_down_cur(req_down_cur),
    .req_current(req_current),
    .req_up_max(req_up_max), .req_down_min(req_down_min),
    .open_button(open_button), .close_button(close_button),
    .cur_floor(cur_floor), .moving_up(moving_up),
    .moving_down(moving_down), .door_open(door_open),
    .clr_floor(clr_floor), .clr_up(clr_up), .clr_down(clr_down)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [16:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  wire [16:0] obs = {cur_floor, moving_up, moving_down, door_open,
                     clr_floor, clr_up, clr_down};

  task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // {cur_floor, mu, md, door, clr_floor, clr_up, clr_down}
  function automatic logic [16:0] ev(int fl, bit mu, bit md, bit dr,
                                     bit cl, bit cu, bit cd);
    logic [5:0] f;
    f = 6'(1) << fl;
    return {f, mu, md, dr, (cl ? f : 6'd0), cu, cd};
  endfunction

  always @(posedge clk) begin
    #1;
    if (sb_q.size() != 0) begin
      sb_t e;
      e = sb_q.pop_front();
      chk(e.tag, {15'd0, obs}, {15'd0, e.exp});
    end
  end

  task automatic step(string tag, logic [16:0] e);
    sb_t s;
    s.tag = tag;
    s.exp = e;
    sb_q.push_back(s);
    @(posedge clk);
    #2;
  endtask

  task automatic clr_in();
    {req_up_in, req_down_in, req_up_out, req_down_out} = '0;
    {req_up_cur, req_down_cur, req_current} = '0;
    {req_up_max, req_down_min, open_button, close_button} = '0;
  endtask

  initial begin
    // Reset with noisy inputs
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      {req_up_in, req_down_in, req_up_out, req_down_out} = 4'($urandom);
      {req_up_cur, req_down_cur, req_current} = 3'($urandom);
      {req_up_max, req_down_min, open_button, close_button} = 4'($urandom);
      step("reset", ev(0, 0, 0, 0, 0, 0, 0));
    end
    clr_in();
    rst_n = 1'b1;
    step("idle0", ev(0, 0, 0, 0, 0, 0, 0));

    // Single trip up to floor 1
    req_up_in = 1;
    for (int i = 1; i <= 8; i++) step("trip_move", ev(0, 1, 0, 0, 0, 0, 0));
    step("trip_arrive", ev(1, 0, 0, 0, 0, 0, 0));
    req_up_in  = 0;
    req_up_cur = 1;
    step("trip_door_entry", ev(1, 0, 0, 1, 1, 1, 0));
    req_up_cur = 0;
    for (int i = 2; i <= 10; i++) step("trip_door", ev(1, 0, 0, 1, 0, 0, 0));
    step("trip_idle", ev(1, 0, 0, 0, 0, 0, 0));

    // Door at current floor beats a pending up request; reopen at cycle 7
    req_current = 1;
    req_up_in   = 1;
    step("reo_entry", ev(1, 0, 0, 1, 1, 1, 0));
    clr_in();
    for (int i = 2; i <= 7; i++) step("reo_door", ev(1, 0, 0, 1, 0, 0, 0));
    open_button = 1;
    step("reo_press", ev(1, 0, 0, 1, 0, 0, 0));
    open_button = 0;
    for (int i = 2; i <= 10; i++) step("reo_hold", ev(1, 0, 0, 1, 0, 0, 0));
    step("reo_idle", ev(1, 0, 0, 0, 0, 0, 0));

    // Close button at door cycle 2
    req_current = 1;
    step("cls_entry", ev(1, 0, 0, 1, 1, 1, 0));
    req_current = 0;
    step("cls_c2", ev(1, 0, 0, 1, 0, 0, 0));
    close_button = 1;
    step("cls_c3", ev(1, 0, 0, 1, 0, 0, 0));
    close_button = 0;
`ifndef ELEV_CLOSE_BUTTON_EN
    for (int i = 4; i <= 10; i++) step("cls_full", ev(1, 0, 0, 1, 0, 0, 0));
`endif
    step("cls_idle", ev(1, 0, 0, 0, 0, 0, 0));

    // Run to the top with an up request held; it must stop at floor 5
    req_up_in = 1;
    for (int f = 1; f <= 4; f++) begin
      for (int i = 1; i <= 8; i++) step("top_move", ev(f, 1, 0, 0, 0, 0, 0));
      step("top_arrive", ev(f + 1, 0, 0, 0, 0, 0, 0));
    end
    for (int i = 0; i < 3; i++) step("top_hold", ev(5, 0, 0, 0, 0, 0, 0));

    // Reversal from the top
    req_up_in   = 0;
    req_down_in = 1;
    for (int i = 1; i <= 8; i++) step("rev_move", ev(5, 0, 1, 0, 0, 0, 0));
    req_down_in = 0;
    step("rev_arrive", ev(4, 0, 0, 0, 0, 0, 0));
    step("rev_idle", ev(4, 0, 0, 0, 0, 0, 0));

    // Mid-travel reset while moving up at counter 3
    req_up_in = 1;
    for (int i = 1; i <= 5; i++) step("mrst_move", ev(4, 1, 0, 0, 0, 0, 0));
    rst_n = 1'b0;
    step("mrst_reset", ev(0, 0, 0, 0, 0, 0, 0));
    req_up_in = 0;
    rst_n     = 1'b1;
    step("mrst_idle", ev(0, 0, 0, 0, 0, 0, 0));

    chk("sb_drain", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
